// File: rtl/sipo_frame_rx_pkg.sv
// Shared serial-link definitions for the shift-register frame receiver and
// its matching transmitter.
package sipo_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } link_state_e;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Even parity holds when the data bits and the parity bit XOR to zero.
  function automatic logic even_parity_ok(input logic [31:0] data, input logic par);
    return ~(^data ^ par);
  endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Parallel valid/ready output bus of the serial frame receiver.
interface sipo_frame_rx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);
endinterface

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register; a word arriving while the entry is
// occupied and not being drained is dropped and flagged as an overrun.
module sipo_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (in_valid) begin
      // A drain on the same edge frees the slot for the arriving word.
      if (!valid_q || out_ready) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even
// parity, stop bit; good words are handed to a one-entry holding register.
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  sipo_frame_rx_if.master  out_if,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             good;
  logic             par_ok;

  assign par_ok = !PARITY_EN || even_parity_ok(32'(shift_q), par_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    good         = 1'b0;
    case (state_q)
      IDLE: begin
        if (si == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        // Shifting in from the top leaves the first bit received in bit 0.
        shift_d = {si, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_d   = si;
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if (si != STOP_BIT) begin
          frame_err_d = 1'b1;
        end else if (!par_ok) begin
          parity_err_d = 1'b1;
        end else begin
          good = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (good),
    .in_data   (shift_q),
    .out_data  (out_if.data_out),
    .out_valid (out_if.out_valid),
    .out_ready (out_if.out_ready),
    .overrun   (overrun)
  );

  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule
